// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage controller: datapath widths,
// the NOP encoding, the PC step, the IF/ID bundle layout and small helpers.
package pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  // IF/ID pipeline register contents; valid is the MSB of the packed vector.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pcplus4;
    logic [XLEN-1:0] instr;
  } ifid_t;

  // Value held in IF/ID after reset or when a taken branch squashes fetch.
  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, pcplus4: {XLEN{1'b0}}, instr: NOP_INSTR};

  // Sequential next PC; wraps naturally modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_reg_ec.sv
// Width-parameterised pipeline register: asynchronous active-high reset,
// enable (holds when low) and a synchronous clear to a fixed value.
// A low enable takes priority over clear so a frozen stage ignores squashes.
module pipe_reg_ec #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}},
  parameter logic [W-1:0] CLR_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Next-state selection: hold, clear, or load.
  always_comb begin
    q_d = q_q;
    if (!en) begin
      q_d = q_q;
    end else if (clr) begin
      q_d = CLR_VAL;
    end else begin
      q_d = d;
    end
  end

  // State flop with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_ctl.sv
// Pipeline stage controller: owns the PC, IF/ID and ID/EX registers and
// applies hazard-unit stall/flush plus the decode-stage branch redirect.
// A sticky watchdog flags stall runs longer than MAX_STALL cycles.
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall/flush cycle
// counters; without it stall_cnt/flush_cnt are tied to zero.
module pipe_stage_ctl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 10,
  parameter int          MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              pcsrc_d,
  input  logic [31:0]       pc_branch_d,
  input  logic [31:0]       instr_f,
  output logic [31:0]       pc_f,
  output logic [31:0]       instr_d,
  output logic [31:0]       pcplus4_d,
  output logic              valid_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [4:0]        rs_d,
  input  logic [4:0]        rt_d,
  input  logic [4:0]        rd_d,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [4:0]        rs_e,
  output logic [4:0]        rt_e,
  output logic [4:0]        rd_e,
  output logic              valid_e,
  output logic              stall_err,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  localparam int IDEX_W    = CTRL_W + 3 * REG_ADDR_W + 1;
  localparam int RUN_W_RAW = $clog2(MAX_STALL + 2);
  localparam int RUN_W     = (RUN_W_RAW < 2) ? 2 : RUN_W_RAW;
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_STALL + 1);

  logic              fetch_en;
  logic [XLEN-1:0]   pc_d;
  logic [XLEN-1:0]   pc_q;
  ifid_t             ifid_d;
  ifid_t             ifid_q;
  logic [IDEX_W-1:0] idex_d;
  logic [IDEX_W-1:0] idex_q;
  logic [RUN_W-1:0]  run_d;
  logic [RUN_W-1:0]  run_q;
  logic              stall_err_d;
  logic              stall_err_q;

  // A stall freezes both the PC and IF/ID; a redirect under stall is dropped.
  assign fetch_en = ~stall_i;

  // Next fetch PC: branch target when taken, otherwise sequential.
  always_comb begin
    pc_d = pc_q;
    if (pcsrc_d) begin
      pc_d = pc_branch_d;
    end else begin
      pc_d = pc_incr(pc_q);
    end
  end

  pipe_reg_ec #(
    .W       (XLEN),
    .RST_VAL (RESET_PC),
    .CLR_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (fetch_en),
    .clr (1'b0),
    .d   (pc_d),
    .q   (pc_q)
  );

  // IF/ID load value: the fetched word and its fall-through address.
  always_comb begin
    ifid_d         = IFID_BUBBLE;
    ifid_d.valid   = 1'b1;
    ifid_d.pcplus4 = pc_incr(pc_q);
    ifid_d.instr   = instr_f;
  end

  pipe_reg_ec #(
    .W       ($bits(ifid_t)),
    .RST_VAL (IFID_BUBBLE),
    .CLR_VAL (IFID_BUBBLE)
  ) u_ifid_reg (
    .clk (clk),
    .rst (rst),
    .en  (fetch_en),
    .clr (pcsrc_d),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  // ID/EX load value: decode bundle plus the validity of the decoded slot.
  always_comb begin
    idex_d = {ifid_q.valid, rd_d, rt_d, rs_d, ctrl_d};
  end

  pipe_reg_ec #(
    .W       (IDEX_W),
    .RST_VAL ({IDEX_W{1'b0}}),
    .CLR_VAL ({IDEX_W{1'b0}})
  ) u_idex_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (flush_i),
    .d   (idex_d),
    .q   (idex_q)
  );

  // Stall watchdog: count the current run and latch an error on overrun.
  always_comb begin
    run_d       = run_q;
    stall_err_d = stall_err_q;
    if (stall_i) begin
      if (run_q != RUN_SAT) begin
        run_d = run_q + RUN_W'(1);
      end else begin
        run_d = run_q;
      end
      if (run_q == RUN_LIMIT) begin
        stall_err_d = 1'b1;
      end else begin
        stall_err_d = stall_err_q;
      end
    end else begin
      run_d       = {RUN_W{1'b0}};
      stall_err_d = stall_err_q;
    end
  end

  // Watchdog state; only reset clears the sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q       <= {RUN_W{1'b0}};
      stall_err_q <= 1'b0;
    end else begin
      run_q       <= run_d;
      stall_err_q <= stall_err_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_d;
  logic [31:0] flush_cnt_q;

  // Saturating hazard cycle counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_i) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_i) begin
      flush_cnt_d = sat_inc32(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif

  assign pc_f      = pc_q;
  assign instr_d   = ifid_q.instr;
  assign pcplus4_d = ifid_q.pcplus4;
  assign valid_d   = ifid_q.valid;
  assign ctrl_e    = idex_q[CTRL_W-1:0];
  assign rs_e      = idex_q[CTRL_W +: REG_ADDR_W];
  assign rt_e      = idex_q[CTRL_W + REG_ADDR_W +: REG_ADDR_W];
  assign rd_e      = idex_q[CTRL_W + 2 * REG_ADDR_W +: REG_ADDR_W];
  assign valid_e   = idex_q[IDEX_W-1];
  assign stall_err = stall_err_q;

endmodule

// File: tb/tb_pipe_stage_ctl.sv
// Self-checking bench for pipe_stage_ctl: expected per-cycle outputs are
// queued when stimulus is applied and popped/compared one cycle later.
module tb_pipe_stage_ctl;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        pcsrc_d;
  logic [31:0] pc_branch_d;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic [9:0]  ctrl_d;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic [4:0]  rd_d;
  logic [9:0]  ctrl_e;
  logic [4:0]  rs_e;
  logic [4:0]  rt_e;
  logic [4:0]  rd_e;
  logic        valid_e;
  logic        stall_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vd;
    logic        ve;
    logic        err;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests;
  int   n_fail;

  pipe_stage_ctl #(
    .RESET_PC  (32'h0000_0000),
    .CTRL_W    (10),
    .MAX_STALL (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .pcsrc_d     (pcsrc_d),
    .pc_branch_d (pc_branch_d),
    .instr_f     (instr_f),
    .pc_f        (pc_f),
    .instr_d     (instr_d),
    .pcplus4_d   (pcplus4_d),
    .valid_d     (valid_d),
    .ctrl_d      (ctrl_d),
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .rd_d        (rd_d),
    .ctrl_e      (ctrl_e),
    .rs_e        (rs_e),
    .rt_e        (rt_e),
    .rd_e        (rd_e),
    .valid_e     (valid_e),
    .stall_err   (stall_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t s;
    s = '{pc: pc_f, instr: instr_d, pc4: pcplus4_d, vd: valid_d, ve: valid_e, err: stall_err};
    return s;
  endfunction

  function automatic obs_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic vd,
                              input logic ve, input logic err);
    obs_t e;
    e = '{pc: pc, instr: instr, pc4: pc4, vd: vd, ve: ve, err: err};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; pcsrc_d = 1'b0;
    pc_branch_d = 32'h0; instr_f = 32'h0; ctrl_d = 10'h0;
    rs_d = 5'd0; rt_d = 5'd0; rd_d = 5'd0;
    #2;
    n_tests++;
    if ({pc_f, instr_d, pcplus4_d, valid_d, ctrl_e, rs_e, rt_e, rd_e, valid_e,
         stall_err, stall_cnt, flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: pc=%h instr=%h pc4=%h vd=%b ctrl=%h ve=%b err=%b sc=%h fc=%h, want all zero",
               pc_f, instr_d, pcplus4_d, valid_d, ctrl_e, valid_e, stall_err, stall_cnt, flush_cnt);
    end
    instr_f = 32'h1234_5678;
    tick();
    tick();
    n_tests++;
    if ({pc_f, instr_d, valid_d, valid_e} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: pc=%h instr=%h vd=%b ve=%b, want 0 0 0 0", pc_f, instr_d, valid_d, valid_e);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    obs_t e;
    obs_t s;
    instr_f = 32'h2001_0005; ctrl_d = 10'h155; rs_d = 5'd1; rt_d = 5'd2; rd_d = 5'd3;
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(mk(32'(4 * i), 32'h2001_0005, 32'(4 * i), 1'b1, (i > 1), 1'b0));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      s = sample();
      n_tests++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL seq[%0d]: got pc=%h instr=%h pc4=%h vd/ve/err=%b, want pc=%h instr=%h pc4=%h vd/ve/err=%b",
                 i, s.pc, s.instr, s.pc4, {s.vd, s.ve, s.err}, e.pc, e.instr, e.pc4, {e.vd, e.ve, e.err});
      end
    end
    n_tests++;
    if ({ctrl_e, rs_e, rt_e, rd_e} !== {10'h155, 5'd1, 5'd2, 5'd3}) begin
      n_fail++;
      $display("FAIL seq_idex: got ctrl=%h rs=%0d rt=%0d rd=%0d, want ctrl=155 rs=1 rt=2 rd=3",
               ctrl_e, rs_e, rt_e, rd_e);
    end
  endtask

  task automatic test_stall_flush();
    obs_t e;
    obs_t s;
    stall_i = 1'b1; flush_i = 1'b1; instr_f = 32'hDEAD_BEEF; ctrl_d = 10'h3FF;
    exp_q.push_back(mk(32'h8, 32'h2001_0005, 32'h8, 1'b1, 1'b0, 1'b0));
    tick();
    e = exp_q.pop_front();
    s = sample();
    n_tests++;
    if (s !== e) begin
      n_fail++;
      $display("FAIL stall_flush_hold: got pc=%h instr=%h pc4=%h vd/ve/err=%b, want pc=%h instr=%h pc4=%h vd/ve/err=%b",
               s.pc, s.instr, s.pc4, {s.vd, s.ve, s.err}, e.pc, e.instr, e.pc4, {e.vd, e.ve, e.err});
    end
    n_tests++;
    if ({ctrl_e, rs_e, rt_e, rd_e} !== 25'h0) begin
      n_fail++;
      $display("FAIL flush_bubble: got ctrl=%h rs=%0d rt=%0d rd=%0d, want all 0", ctrl_e, rs_e, rt_e, rd_e);
    end
    stall_i = 1'b0; flush_i = 1'b0; instr_f = 32'h2002_0006; ctrl_d = 10'h155;
    exp_q.push_back(mk(32'hC, 32'h2002_0006, 32'hC, 1'b1, 1'b1, 1'b0));
    tick();
    e = exp_q.pop_front();
    s = sample();
    n_tests++;
    if (s !== e) begin
      n_fail++;
      $display("FAIL stall_flush_resume: got pc=%h instr=%h pc4=%h vd/ve/err=%b, want pc=%h instr=%h pc4=%h vd/ve/err=%b",
               s.pc, s.instr, s.pc4, {s.vd, s.ve, s.err}, e.pc, e.instr, e.pc4, {e.vd, e.ve, e.err});
    end
    n_tests++;
    if (ctrl_e !== 10'h155) begin
      n_fail++;
      $display("FAIL flush_release_ctrl: got %h want 155", ctrl_e);
    end
  endtask

  task automatic test_branch();
    obs_t e;
    obs_t s;
    pcsrc_d = 1'b1; pc_branch_d = 32'h40;
    exp_q.push_back(mk(32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h44, 32'h2003_0007, 32'h44, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      tick();
      pcsrc_d = 1'b0; instr_f = 32'h2003_0007;
      e = exp_q.pop_front();
      s = sample();
      n_tests++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL branch[%0d]: got pc=%h instr=%h pc4=%h vd/ve/err=%b, want pc=%h instr=%h pc4=%h vd/ve/err=%b",
                 i, s.pc, s.instr, s.pc4, {s.vd, s.ve, s.err}, e.pc, e.instr, e.pc4, {e.vd, e.ve, e.err});
      end
    end
  endtask

  task automatic test_stall_branch();
    obs_t e;
    obs_t s;
    logic stl[3];
    logic br[3];
    stl = '{1'b1, 1'b0, 1'b0};
    br  = '{1'b1, 1'b1, 1'b0};
    pc_branch_d = 32'h100;
    exp_q.push_back(mk(32'h44, 32'h2003_0007, 32'h44, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h100, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h104, 32'h2003_0007, 32'h104, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      stall_i = stl[i];
      pcsrc_d = br[i];
      tick();
      e = exp_q.pop_front();
      s = sample();
      n_tests++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL stall_branch[%0d]: got pc=%h instr=%h pc4=%h vd/ve/err=%b, want pc=%h instr=%h pc4=%h vd/ve/err=%b",
                 i, s.pc, s.instr, s.pc4, {s.vd, s.ve, s.err}, e.pc, e.instr, e.pc4, {e.vd, e.ve, e.err});
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e;
    obs_t s;
    exp_q.push_back(mk(32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(32'hFFFF_FFFC, 32'h2003_0007, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h0, 32'h2003_0007, 32'h0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h4, 32'h2003_0007, 32'h4, 1'b1, 1'b1, 1'b0));
    pcsrc_d = 1'b1; pc_branch_d = 32'hFFFF_FFF8;
    for (int i = 0; i < 4; i++) begin
      tick();
      pcsrc_d = 1'b0;
      e = exp_q.pop_front();
      s = sample();
      n_tests++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got pc=%h instr=%h pc4=%h vd/ve/err=%b, want pc=%h instr=%h pc4=%h vd/ve/err=%b",
                 i, s.pc, s.instr, s.pc4, {s.vd, s.ve, s.err}, e.pc, e.instr, e.pc4, {e.vd, e.ve, e.err});
      end
    end
  endtask

  task automatic test_watchdog();
    obs_t e;
    obs_t s;
    logic        stl[10];
    logic [31:0] pc;
    int          run;
    logic        err;
    stl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    pc = 32'h4; run = 0; err = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (stl[i]) begin
        run = run + 1;
        if (run > 3) err = 1'b1;
      end else begin
        run = 0;
        pc = pc + 32'd4;
      end
      exp_q.push_back(mk(pc, 32'h2003_0007, pc, 1'b1, 1'b1, err));
    end
    for (int i = 0; i < 10; i++) begin
      stall_i = stl[i];
      tick();
      e = exp_q.pop_front();
      s = sample();
      n_tests++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL watchdog[%0d]: got pc=%h instr=%h pc4=%h vd/ve/err=%b, want pc=%h instr=%h pc4=%h vd/ve/err=%b",
                 i, s.pc, s.instr, s.pc4, {s.vd, s.ve, s.err}, e.pc, e.instr, e.pc4, {e.vd, e.ve, e.err});
      end
    end
    stall_i = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    obs_t e;
    obs_t s;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    stall_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, (i >= 4)));
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      e = exp_q.pop_front();
      s = sample();
      n_tests++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL fresh_stall[%0d]: got pc=%h instr=%h pc4=%h vd/ve/err=%b, want pc=%h instr=%h pc4=%h vd/ve/err=%b",
                 i, s.pc, s.instr, s.pc4, {s.vd, s.ve, s.err}, e.pc, e.instr, e.pc4, {e.vd, e.ve, e.err});
      end
    end
`ifdef PIPE_PERF_CNT_EN
    n_tests++;
    if (stall_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d want 5", stall_cnt);
    end
`endif
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({pc_f, instr_d, pcplus4_d, valid_d, ctrl_e, rs_e, rt_e, rd_e, valid_e,
         stall_err, stall_cnt, flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_stall: pc=%h instr=%h vd=%b ve=%b err=%b sc=%h fc=%h, want all zero",
               pc_f, instr_d, valid_d, valid_e, stall_err, stall_cnt, flush_cnt);
    end
    tick();
    rst = 1'b0;
    stall_i = 1'b0;
    tick();
    n_tests++;
    if ({pc_f, valid_d, stall_err} !== {32'h4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_run: got pc=%h vd=%b err=%b, want pc=4 vd=1 err=0", pc_f, valid_d, stall_err);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_sequential();
    test_stall_flush();
    test_branch();
    test_stall_branch();
    test_wrap();
    test_watchdog();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctl.md
Name: pipe_stage_ctl

Overview:
Responder side of the hazard interface. Owns the PC register, the IF/ID pipeline register and the ID/EX pipeline register, and applies the hazard unit's Stall/Flush requests and the decode-stage branch redirect to them. Sits between instruction memory/decode and execute. Also tracks over-long stalls with a sticky error flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CTRL_W, 10, width of the decode control bundle carried into EX
MAX_STALL, 3, longest legal run of consecutive stall cycles before stall_err sets

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall_i  in  1  Stall from hazard unit; freezes PC and IF/ID
flush_i  in  1  Flush from hazard unit; inserts bubble into ID/EX
pcsrc_d  in  1  branch taken, resolved in decode
pc_branch_d  in  32  branch target from decode
instr_f  in  32  instruction word from instruction memory
pc_f  out  32  current fetch PC
instr_d  out  32  IF/ID instruction
pcplus4_d  out  32  IF/ID PC+4
valid_d  out  1  IF/ID holds a real instruction
ctrl_d  in  CTRL_W  decode control bundle
rs_d, rt_d, rd_d  in  5 each  decode register fields
ctrl_e  out  CTRL_W  ID/EX control bundle
rs_e, rt_e, rd_e  out  5 each  ID/EX register fields
valid_e  out  1  ID/EX holds a real instruction
stall_err  out  1  sticky: stall exceeded MAX_STALL cycles
stall_cnt  out  32  stall-cycle count (optional feature)
flush_cnt  out  32  flush-cycle count (optional feature)

Behaviour:
- Reset (async, rst=1): pc_f=RESET_PC; instr_d=32'h0 (NOP); pcplus4_d=0; valid_d=0; ctrl_e=0; rs_e=rt_e=rd_e=0; valid_e=0; stall_err=0; stall_cnt=flush_cnt=0. Reset mid-stall or mid-branch discards all state.
- PC, per clk edge, priority order: stall_i -> hold; pcsrc_d -> pc_branch_d; else pc_f+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
- IF/ID, priority order: stall_i -> hold all fields; pcsrc_d -> clear to NOP, valid_d=0; else instr_d<=instr_f, pcplus4_d<=pc_f+4, valid_d<=1.
- stall_i together with pcsrc_d: stall wins, redirect ignored this cycle; decode re-presents the branch after the stall.
- ID/EX, never held: flush_i -> ctrl_e=0, rs_e=rt_e=rd_e=0, valid_e=0 (bubble). Otherwise capture ctrl_d, rs_d/rt_d/rd_d; valid_e<=valid_d.
- Latency: instr_f to instr_d 1 cycle; decode fields to EX fields 1 cycle.
- Stall watchdog: 2-bit-min run counter, increments while stall_i=1 (saturating), clears when stall_i=0. stall_err sets on the cycle the run reaches MAX_STALL+1. Only rst clears it.

Optional Feature:
PIPE_PERF_CNT_EN defined: stall_cnt increments every cycle stall_i=1; flush_cnt increments every cycle flush_i=1; both saturate at 32'hFFFF_FFFF. Not defined: ports remain, tied to 0, no counter flops.

Decomposition:
- Shared package pipe_pkg: NOP_INSTR=32'h0, REG_ADDR_W=5, XLEN=32, PC_STEP=4.
- One sub-module: pipe_reg_ec, a width-parameterised register with async reset, enable (hold when low), sync clear and clear value. Instantiated for PC, IF/ID, ID/EX.

Test Plan:
- Reset release, no hazards, instr_f=32'h2001_0005 -> pc_f 0,4,8,...; instr_d=32'h2001_0005 one cycle later, valid_d=1.
- stall_i=flush_i=1 for 1 cycle at pc_f=8 -> pc_f stays 8, instr_d/pcplus4_d held, next cycle valid_e=0, ctrl_e=0.
- pcsrc_d=1, pc_branch_d=32'h40, no stall -> next pc_f=32'h40, instr_d=0, valid_d=0.
- stall_i=1 and pcsrc_d=1 same cycle -> pc_f held, redirect not taken; pcsrc_d held through next cycle with stall low -> pc_f=target.
- stall_i high 4 cycles, MAX_STALL=3 -> stall_err=1 after 4th edge, stays 1 after stall drops; 3-cycle run leaves it 0.
- Assert rst mid-stall with PIPE_PERF_CNT_EN, stall_cnt=5 -> all outputs to reset values immediately, stall_cnt=0.
